// File: rtl/elevator_ctrl_n.sv
// Parametrised N-floor elevator controller: collective (SCAN) call service, travel/door timers, SOS, overweight.
// Optional feature: define DOOR_REOPEN_EN so a call at the current floor restarts the door timer.
module elevator_ctrl_n #(
  parameter int FLOORS          = 4,
  parameter int TICKS_PER_FLOOR = 2,
  parameter int DOOR_TICKS      = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       tick,
  input  logic [FLOORS-1:0]          call_req,
  input  logic                       sos,
  input  logic                       overweight,
  output logic [FLOORS-1:0]          call_led,
  output logic [FLOORS-1:0]          floor_oh,
  output logic [$clog2(FLOORS)-1:0]  floor_idx,
  output logic                       door_open,
  output logic                       moving,
  output logic                       dir_up,
  output logic                       sos_mode,
  output logic                       weight_limit_exceeded
);

  localparam int FW = $clog2(FLOORS);
  localparam int TW = (TICKS_PER_FLOOR > 1) ? $clog2(TICKS_PER_FLOOR) : 1;
  localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2,
    SOS  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [FW-1:0]       floor_q, floor_d;
  logic                dir_q, dir_d;
  logic [FLOORS-1:0]   call_q, call_d;
  logic [TW-1:0]       travel_q, travel_d;
  logic [DW-1:0]       door_cnt_q, door_cnt_d;
  logic                weight_q, weight_d;
  logic [FLOORS-1:0]   floor_oh_q, floor_oh_d;
  logic                door_open_q, moving_q, sos_mode_q;
  logic [FLOORS-1:0]   pend;
  logic [FW-1:0]       next_floor;

  function automatic logic calls_above(input logic [FLOORS-1:0] c, input logic [FW-1:0] f);
    calls_above = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if ((FW'(i) > f) && c[i]) calls_above = 1'b1;
    end
  endfunction

  function automatic logic calls_below(input logic [FLOORS-1:0] c, input logic [FW-1:0] f);
    calls_below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if ((FW'(i) < f) && c[i]) calls_below = 1'b1;
    end
  endfunction

  // Adjacent floor in the current direction, clamped so the car never leaves the shaft.
  always_comb begin
    next_floor = floor_q;
    if (dir_q && (floor_q != FW'(FLOORS - 1))) begin
      next_floor = floor_q + FW'(1);
    end else if (!dir_q && (floor_q != '0)) begin
      next_floor = floor_q - FW'(1);
    end
  end

  // Next-state logic; sos overrides everything, including arrival and overweight.
  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_d      = dir_q;
    call_d     = call_q;
    travel_d   = travel_q;
    door_cnt_d = door_cnt_q;
    weight_d   = 1'b0;
    pend       = call_q | call_req;

    if (sos) begin
      state_d    = SOS;
      call_d     = '0;
      door_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          call_d = pend;
          if (pend[floor_q]) begin
            state_d         = DOOR;
            door_cnt_d      = '0;
            call_d[floor_q] = 1'b0;
          end else if (dir_q ? calls_above(pend, floor_q) : calls_below(pend, floor_q)) begin
            state_d = MOVE;
          end else if (calls_above(pend, floor_q) || calls_below(pend, floor_q)) begin
            dir_d   = ~dir_q;
            state_d = MOVE;
          end
        end

        MOVE: begin
          call_d = pend;
          if (tick) begin
            if (travel_q == TW'(TICKS_PER_FLOOR - 1)) begin
              travel_d = '0;
              floor_d  = next_floor;
              if (pend[next_floor]) begin
                state_d            = DOOR;
                door_cnt_d         = '0;
                call_d[next_floor] = 1'b0;
              end else if (dir_q ? calls_above(pend, next_floor) : calls_below(pend, next_floor)) begin
                state_d = MOVE;
              end else if (dir_q ? calls_below(pend, next_floor) : calls_above(pend, next_floor)) begin
                dir_d   = ~dir_q;
                state_d = MOVE;
              end else begin
                state_d = IDLE;
              end
            end else begin
              travel_d = travel_q + TW'(1);
            end
          end
        end

        DOOR: begin
          call_d          = pend;
          call_d[floor_q] = 1'b0;
          if (overweight) begin
            weight_d   = 1'b1;
            door_cnt_d = '0;
`ifdef DOOR_REOPEN_EN
          end else if (call_req[floor_q]) begin
            door_cnt_d = '0;
`endif
          end else if (tick) begin
            if (door_cnt_q == DW'(DOOR_TICKS - 1)) begin
              state_d    = IDLE;
              door_cnt_d = '0;
            end else begin
              door_cnt_d = door_cnt_q + DW'(1);
            end
          end
        end

        SOS: begin
          call_d  = '0;
          state_d = (travel_q != '0) ? MOVE : IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    floor_oh_d          = '0;
    floor_oh_d[floor_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      floor_q     <= '0;
      dir_q       <= 1'b1;
      call_q      <= '0;
      travel_q    <= '0;
      door_cnt_q  <= '0;
      weight_q    <= 1'b0;
      floor_oh_q  <= FLOORS'(1);
      door_open_q <= 1'b0;
      moving_q    <= 1'b0;
      sos_mode_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      floor_q     <= floor_d;
      dir_q       <= dir_d;
      call_q      <= call_d;
      travel_q    <= travel_d;
      door_cnt_q  <= door_cnt_d;
      weight_q    <= weight_d;
      floor_oh_q  <= floor_oh_d;
      door_open_q <= (state_d == DOOR);
      moving_q    <= (state_d == MOVE);
      sos_mode_q  <= (state_d == SOS);
    end
  end

  assign call_led              = call_q;
  assign floor_oh              = floor_oh_q;
  assign floor_idx             = floor_q;
  assign door_open             = door_open_q;
  assign moving                = moving_q;
  assign dir_up                = dir_q;
  assign sos_mode              = sos_mode_q;
  assign weight_limit_exceeded = weight_q;

endmodule
